// File: rtl/perf_sampler_pkg.sv
// Shared types and constants for the performance-counter sampler.
// Counter-bank geometry and the sample record layout live here.
package perf_sampler_pkg;

  localparam int unsigned XLEN           = 64;
  localparam int unsigned MHPMCounterNum = 6;

  localparam logic [11:0] CSR_MHPM_COUNTER_3  = 12'hB03;
  localparam logic [11:0] CSR_MHPM_COUNTER_3H = 12'hB83;

  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] seq;
    logic [63:0] data;
  } perf_sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_LO = 2'd1,
    RD_HI = 2'd2,
    CLR   = 2'd3
  } sampler_state_e;

endpackage

// File: rtl/perf_sampler_fifo.sv
// Sample FIFO: power-of-two depth, show-ahead head, push accepted when full
// if a pop happens in the same cycle.
module perf_sampler_fifo #(
  parameter int unsigned Depth = 8,
  parameter int unsigned Width = 85
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam logic [AddrW:0] FullCnt = (AddrW + 1)'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == FullCnt);
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AddrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AddrW + 1)'(1);
      else if (!do_push && do_pop) count_q <= count_q - (AddrW + 1)'(1);
    end
  end

  // Storage needs no reset: emptiness is tracked by count_q alone.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/perf_sampler.sv
// Periodic / triggered scanner of the mhpmcounter bank into a sample FIFO.
// Optional clear-on-read (delta sampling) with PERF_SAMPLER_CLEAR_ON_READ_EN.
//
// state | meaning
// IDLE  | waiting for a pending scan request
// RD_LO | addressing counter idx (low word, or full word when XLEN=64)
// RD_HI | addressing the high word of counter idx (XLEN=32 only)
// CLR   | writing zero back to the counter just captured
module perf_sampler
  import perf_sampler_pkg::*;
#(
  parameter int unsigned NumCounters = MHPMCounterNum,
  parameter int unsigned FifoDepth   = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   debug_mode_i,
  input  logic                   cfg_en_i,
  input  logic [31:0]            cfg_period_i,
  input  logic [NumCounters-1:0] cfg_mask_i,
  input  logic                   trigger_i,
  input  logic                   overflow_clr_i,
  output logic [11:0]            perf_addr_o,
  output logic                   perf_we_o,
  output logic [XLEN-1:0]        perf_data_o,
  input  logic [XLEN-1:0]        perf_data_i,
  output logic                   sample_valid_o,
  input  logic                   sample_ready_i,
  output logic [4:0]             sample_idx_o,
  output logic [15:0]            sample_seq_o,
  output logic [63:0]            sample_data_o,
  output logic                   busy_o,
  output logic                   overflow_o
);

`ifdef PERF_SAMPLER_CLEAR_ON_READ_EN
  localparam bit ClearOnRead = 1'b1;
`else
  localparam bit ClearOnRead = 1'b0;
`endif

  sampler_state_e state_q;
  logic [4:0]     idx_q;
  logic [15:0]    seq_q;
  logic [31:0]    timer_q;
  logic           pending_q, overflow_q;
  logic [31:0]    mask_ext;
  logic           mask_hit, last_idx, idx_done, clr_hi;
  logic           timer_expire, timer_reload, start_scan;
  logic           push, pop, drop, fifo_full, fifo_empty;
  logic [63:0]    capture;
  perf_sample_t   push_data, head;

  assign mask_ext = 32'(cfg_mask_i);
  assign mask_hit = mask_ext[idx_q];
  assign last_idx = (idx_q == 5'(NumCounters - 1));

  assign timer_expire = cfg_en_i && (cfg_period_i != '0) && !debug_mode_i &&
                        (timer_q == 32'd1);
  // A zero count while enabled would otherwise underflow into a ~2^32 wait.
  assign timer_reload = !cfg_en_i || (cfg_period_i == '0) || (timer_q == '0) ||
                        timer_expire;
  assign start_scan   = (state_q == IDLE) && pending_q;

  if (XLEN == 64) begin : g_x64
    assign capture = 64'(perf_data_i);
    assign push    = (state_q == RD_LO) && mask_hit;
  end else begin : g_x32
    logic [31:0] lo_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                               lo_q <= '0;
      else if ((state_q == RD_LO) && mask_hit)   lo_q <= perf_data_i[31:0];
    end
    assign capture = {perf_data_i[31:0], lo_q};
    assign push    = (state_q == RD_HI);
  end

`ifdef PERF_SAMPLER_CLEAR_ON_READ_EN
  logic clr_hi_q;
  // Second CLR cycle (XLEN=32) targets the high half of the counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) clr_hi_q <= 1'b0;
    else         clr_hi_q <= (state_q == CLR) && !clr_hi_q && (XLEN == 32);
  end
  assign clr_hi    = clr_hi_q;
  assign perf_we_o = (state_q == CLR);
`else
  assign clr_hi    = 1'b0;
  assign perf_we_o = 1'b0;
`endif
  assign perf_data_o = '0;

  always_comb begin
    perf_addr_o = CSR_MHPM_COUNTER_3 + 12'(idx_q);
    if ((state_q == RD_HI) || ((state_q == CLR) && clr_hi))
      perf_addr_o = CSR_MHPM_COUNTER_3H + 12'(idx_q);
  end

  // idx_done marks the final cycle spent on the current index.
  always_comb begin
    idx_done = 1'b0;
    case (state_q)
      RD_LO:   idx_done = !mask_hit || ((XLEN == 64) && !ClearOnRead);
      RD_HI:   idx_done = !ClearOnRead;
      CLR:     idx_done = (XLEN == 64) || clr_hi;
      default: idx_done = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      seq_q      <= '0;
      timer_q    <= '0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (timer_reload)       timer_q <= cfg_period_i;
      else if (!debug_mode_i) timer_q <= timer_q - 32'd1;

      pending_q <= (pending_q && !start_scan) || trigger_i || timer_expire;

      if (drop)                overflow_q <= 1'b1;
      else if (overflow_clr_i) overflow_q <= 1'b0;

      if (start_scan) begin
        state_q <= RD_LO;
        idx_q   <= '0;
      end else if (idx_done) begin
        if (last_idx) begin
          state_q <= IDLE;
          idx_q   <= '0;
          seq_q   <= seq_q + 16'd1;
        end else begin
          state_q <= RD_LO;
          idx_q   <= idx_q + 5'd1;
        end
      end else begin
        case (state_q)
          RD_LO:   state_q <= (XLEN == 32) ? RD_HI : CLR;
          RD_HI:   state_q <= CLR;
          default: state_q <= state_q;
        endcase
      end
    end
  end

  assign push_data = '{idx: idx_q, seq: seq_q, data: capture};
  assign pop       = sample_valid_o && sample_ready_i;
  assign drop      = push && fifo_full && !pop;

  perf_sampler_fifo #(
    .Depth (FifoDepth),
    .Width ($bits(perf_sample_t))
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign sample_valid_o = !fifo_empty;
  assign sample_idx_o   = head.idx;
  assign sample_seq_o   = head.seq;
  assign sample_data_o  = head.data;
  assign busy_o         = (state_q != IDLE);
  assign overflow_o     = overflow_q;

endmodule
